// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control encodings and request/response types shared by the ALU and its arbiter.
package alu_pkg;

  localparam logic [2:0] ALU_CTRL_ADD = 3'b000;
  localparam logic [2:0] ALU_CTRL_SUB = 3'b001;
  localparam logic [2:0] ALU_CTRL_AND = 3'b010;
  localparam logic [2:0] ALU_CTRL_OR  = 3'b011;
  localparam logic [2:0] ALU_CTRL_SLT = 3'b101;

  typedef struct packed {
    logic [31:0] srca;
    logic [31:0] srcb;
    logic [2:0]  ctrl;
  } alu_req_t;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
  } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - Combinational 32-bit ALU: add, sub, and, or, signed set-less-than.
module alu
  import alu_pkg::*;
(
  input  alu_req_t req,
  output alu_rsp_t rsp
);

  logic [31:0] result;

  always_comb begin
    result = '0;
    unique case (req.ctrl)
      ALU_CTRL_ADD: result = req.srca + req.srcb;
      ALU_CTRL_SUB: result = req.srca - req.srcb;
      ALU_CTRL_AND: result = req.srca & req.srcb;
      ALU_CTRL_OR:  result = req.srca | req.srcb;
      ALU_CTRL_SLT: result = {31'b0, $signed(req.srca) < $signed(req.srcb)};
      default:      result = '0;
    endcase
  end

  assign rsp.result = result;
  assign rsp.zero   = (result == '0);

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - Round-robin sharing of one ALU between two requesters with registered per-requester responses.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int FIRST_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_srca,
  input  logic [31:0] req0_srcb,
  input  logic [2:0]  req0_ctrl,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_srca,
  input  logic [31:0] req1_srcb,
  input  logic [2:0]  req1_ctrl,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero
);

  localparam logic PRIO_RST = (FIRST_PRIO != 0);

  logic     prio;
  logic     elig0, elig1;
  logic     grant0, grant1;
  alu_req_t alu_in;
  alu_rsp_t alu_out;

  // A slot can take a new result if it is empty or being drained this cycle.
  always_comb begin
    elig0  = req0_valid && (!rsp0_valid || rsp0_ready);
    elig1  = req1_valid && (!rsp1_valid || rsp1_ready);
    grant0 = rst_n && elig0 && (!elig1 || !prio);
    grant1 = rst_n && elig1 && (!elig0 || prio);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    alu_in.srca = req0_srca;
    alu_in.srcb = req0_srcb;
    alu_in.ctrl = req0_ctrl;
    if (grant1) begin
      alu_in.srca = req1_srca;
      alu_in.srcb = req1_srcb;
      alu_in.ctrl = req1_ctrl;
    end
  end

  alu u_alu (
    .req (alu_in),
    .rsp (alu_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio        <= PRIO_RST;
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
    end else begin
      if (grant0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= alu_out.result;
        rsp0_zero   <= alu_out.zero;
      end else if (rsp0_ready) begin
        rsp0_valid  <= 1'b0;
      end

      if (grant1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= alu_out.result;
        rsp1_zero   <= alu_out.zero;
      end else if (rsp1_ready) begin
        rsp1_valid  <= 1'b0;
      end

      // Priority flips after every grant, contested or not.
      if (grant0)      prio <= 1'b1;
      else if (grant1) prio <= 1'b0;
    end
  end

endmodule
